// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and fixed values.
// Other files pull these in with import cp0_unit_pkg::*.
package cp0_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_NONE = 5'd0;

    localparam logic [DATA_W-1:0] PRID_VAL    = 32'h0000_2019;
    localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Restart address for the trapping instruction: a delay-slot
    // instruction restarts at its branch. The result is always word aligned.
    function automatic logic [DATA_W-1:0] epc_of(input logic [DATA_W-1:0] pc,
                                                 input logic              bd);
        logic [DATA_W-1:0] a;
        a = bd ? (pc - 32'd4) : pc;
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// MIPS-style coprocessor 0: SR, Cause, EPC, PRId and an inline Count/Compare timer.
// IntReq is decided combinationally in M stage; state commits on the next edge.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [DATA_W-1:0] DIn,
    input  logic              WE,
    input  logic [DATA_W-1:0] PC,
    input  logic              BDIn,
    input  logic [4:0]        ExcCodeIn,
    input  logic [5:0]        HWInt,
    input  logic              EXLClr,
    output logic              IntReq,
    output logic [DATA_W-1:0] EPCOut,
    output logic [DATA_W-1:0] DOut
);

    logic [5:0]        r_im;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic [5:0]        r_ip;
    logic [4:0]        r_exccode;
    logic [DATA_W-1:0] r_epc;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_compare;
    logic              r_ti;
    logic              r_post_rst;

    logic [5:0]        w_ip_next;
    logic              w_int_pend;
    logic              w_take;
    logic              w_wr;

    // The timer shares the top interrupt line with HWInt[5].
    assign w_ip_next  = {HWInt[5] | r_ti, HWInt[4:0]};
    assign w_int_pend = r_ie && (|(w_ip_next & r_im));
    // r_post_rst masks the first cycle out of reset so nothing is taken
    // before the pipeline has refilled.
    assign w_take     = !r_post_rst && !r_exl &&
                        (w_int_pend || (ExcCodeIn != EXC_NONE));
    assign w_wr       = WE && !w_take;

    assign IntReq = w_take;
    assign EPCOut = r_epc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exccode  <= '0;
            r_epc      <= '0;
            r_count    <= '0;
            r_compare  <= COMPARE_RST;
            r_ti       <= 1'b0;
            r_post_rst <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
            r_ip       <= w_ip_next;
            r_count    <= r_count + 32'd1;
            if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
            if (w_take) begin
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_pend ? EXC_INT : ExcCodeIn;
                r_epc     <= epc_of(PC, BDIn);
            end else begin
                if (w_wr) begin
                    case (A2)
                        CP0_SR: begin
                            r_im  <= DIn[15:10];
                            r_exl <= DIn[1];
                            r_ie  <= DIn[0];
                        end
                        CP0_EPC:     r_epc   <= DIn;
                        CP0_COUNT:   r_count <= DIn;
                        CP0_COMPARE: begin
                            r_compare <= DIn;
                            r_ti      <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                // eret wins over an mtc0 that tries to set EXL in the same cycle.
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            CP0_SR:      DOut = {16'h0000, r_im, 8'h00, r_exl, r_ie};
            CP0_CAUSE:   DOut = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};
            CP0_EPC:     DOut = r_epc;
            CP0_PRID:    DOut = PRID_VAL;
            CP0_COUNT:   DOut = r_count;
            CP0_COMPARE: DOut = r_compare;
            default:     DOut = '0;
        endcase
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL: A1  in  5  read register number (mfc0 rd).
REQ-004 SHALL: A2  in  5  write register number (mtc0 rd).
REQ-005 SHALL: DIn  in  32  write data (mtc0 rt value).
REQ-006 SHALL: WE  in  1  CP0 write enable (controller CP0Write, M stage).
REQ-007 SHALL: PC  in  32  PC of M-stage instruction.
REQ-008 SHALL: BDIn  in  1  M-stage instruction sits in a delay slot.
REQ-009 SHALL: ExcCodeIn  in  5  synchronous exception code; 0 = none (4 AdEL, 5 AdES, 10 RI, 12 Ov).
REQ-010 SHALL: HWInt  in  6  external interrupt lines, bits [7:2] of IP.
REQ-011 SHALL: EXLClr  in  1  eret in M stage.
REQ-012 SHALL: IntReq  out  1  take exception/interrupt this cycle; flush pipeline, PC := 0x0000_4180.
REQ-013 SHALL: EPCOut  out  32  current EPC for eret.
REQ-014 SHALL: DOut  out  32  combinational read of register A1.

Function
REQ-015 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-016 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
REQ-017 SHALL implement EPC (14, 32-bit), PRId (15, constant 0x0000_2019), Count (9), Compare (11).
REQ-018 SHALL read 0 on DOut for any unimplemented A1.
REQ-019 SHALL increment Count by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-020 SHALL set a timer-pending flag TI when Count == Compare and clear TI on any Compare write.
REQ-021 SHALL load Cause.IP every cycle from {HWInt[5] | TI, HWInt[4:0]}.
REQ-022 SHALL assert IntReq = !EXL && ((IE && |(IPnext & IM)) || ExcCodeIn != 0); IPnext is this cycle's IP input value.
REQ-023 SHALL give interrupts priority over exceptions; on interrupt, ExcCode := 0.
REQ-024 SHALL, on an IntReq cycle edge: EXL := 1, Cause.BD := BDIn, ExcCode := chosen code, EPC := BDIn ? PC-4 : PC, low 2 bits forced 0.
REQ-025 SHALL ignore WE in an IntReq cycle; the interrupted instruction does not commit.
REQ-026 SHALL, when WE and not IntReq, write SR, EPC, Count or Compare per A2, masked to implemented bits; writes to Cause and PRId are ignored.
REQ-027 SHALL clear EXL on the edge where EXLClr is 1; EXLClr beats a same-cycle mtc0 to SR.EXL.
REQ-028 SHALL let an mtc0 Count write override the increment in that cycle.
REQ-029 SHALL drive EPCOut directly from the EPC register; a same-cycle mtc0 EPC write is not forwarded.

Reset
REQ-030 SHALL, while reset_n = 0 at an edge, clear SR, Cause, EPC, Count and TI, and set Compare to 0xFFFF_FFFF.
REQ-031 SHALL hold IntReq at 0 in the cycle after reset; outputs reflect the cleared registers.
REQ-032 SHALL give reset priority over IntReq, WE and EXLClr.

Structure
REQ-033 SHALL take register numbers, ExcCode values, the handler address and the PRId constant from shared head.v defines.
REQ-034 SHALL be a single module; no sub-module is required (the timer stays inline).

Verification
REQ-035 SHALL cover: SR=0x0000_0401 (IM[10], IE) with HWInt=6'b000001 -> IntReq=1 the same cycle; next cycle EXL=1, ExcCode=0, EPC=PC.
REQ-036 SHALL cover: ExcCodeIn=10, BDIn=1, PC=0x3008 -> IntReq=1; EPC=0x3004, Cause.BD=1, Cause[6:2]=10.
REQ-037 SHALL cover: EXL=1 with pending HWInt and Ov -> IntReq=0; EXLClr pulse -> EXL=0; IntReq=1 the next cycle.
REQ-038 SHALL cover: mtc0 Compare=5, then Count=0 with SR IM[15], IE=1 -> IntReq asserts when Count reaches 5; a Compare write clears TI.
REQ-039 SHALL cover: WE=1 to SR (A2=12) together with ExcCodeIn=12 -> SR keeps its prior IM/IE, EXL=1.
REQ-040 SHALL cover: reset_n=0 mid-exception (EXL=1, EPC set) -> all registers cleared, DOut(A1=15)=0x0000_2019.
